seven_seg_digit_driver: RTL

// - Consumes the 2-bit digit-scan index from the display scan counter and drives the 4-digit

---
 rtl/seg_pkg.sv | 16 +
 rtl/hex_to_seg_n.sv | 9 +
 rtl/seven_seg_digit_driver.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, segment lookup table and display buffer type
// for the four-digit common-anode seven-segment driver.
package seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;
    // index 0 sits in the low bits: {F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0}
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    typedef struct packed {
        logic [15:0] nibbles;
        logic [3:0]  dp;
        logic [3:0]  en;
    } disp_buf_t;
endpackage

// File: rtl/hex_to_seg_n.sv
// hex_to_seg_n: combinational hex nibble to active-low {g,f,e,d,c,b,a} pattern.
module hex_to_seg_n
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);
    assign o_seg_n = SEG_TABLE[i_nibble];
endmodule

// File: rtl/seven_seg_digit_driver.sv
// seven_seg_digit_driver: drives anode/segment/dp pins for a scanned 4-digit display
// with frame-synchronous double buffering, anti-ghost blanking, leading-zero blanking and blink.
module seven_seg_digit_driver
    import seg_pkg::*;
#(
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_HALF   = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  scan_sel,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        load,
    input  logic        lzb,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam int KW = $clog2(BLINK_HALF);

    logic [1:0]    r_scan_q;
    logic [BW-1:0] r_blank_cnt;
    logic [KW-1:0] r_blink_cnt;
    logic          r_blink_off;
    logic          r_pending;
    disp_buf_t     r_shadow;
    disp_buf_t     r_active;
    logic [3:0]    r_an_n;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic          r_frame_done;

    disp_buf_t     w_in;
    logic          w_change;
    logic          w_wrap;
    logic          w_lead_zero;
    logic          w_show;
    logic          w_blink_end;
    logic [BW-1:0] w_cnt_next;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_n;

    assign w_in        = {digits, dp_in, digit_en};
    assign w_change    = scan_sel != r_scan_q;
    assign w_wrap      = w_change && r_scan_q == 2'd3 && scan_sel == 2'd0;
    assign w_cnt_next  = w_change ? BW'(BLANK_CYCLES) : (r_blank_cnt != '0 ? r_blank_cnt - 1'b1 : '0);
    assign w_nibble    = r_active.nibbles[{r_scan_q, 2'b00} +: 4];
    assign w_lead_zero = lzb && r_scan_q != 2'd0 && (r_active.nibbles >> {r_scan_q, 2'b00}) == 16'h0;
    assign w_blink_end = r_blink_cnt == KW'(BLINK_HALF - 1);
    // a pending scan change forces w_cnt_next non-zero, so the pins go dark on the same edge
    assign w_show      = w_cnt_next == '0 && r_active.en[r_scan_q] && !w_lead_zero
                         && !(r_blink_off && blink_mask[r_scan_q]);

    hex_to_seg_n u_dec (
        .i_nibble (w_nibble),
        .o_seg_n  (w_seg_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_q     <= '0;
            r_blank_cnt  <= BW'(BLANK_CYCLES);
            r_frame_done <= 1'b0;
            r_an_n       <= AN_OFF;
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
        end else begin
            r_scan_q     <= scan_sel;
            r_blank_cnt  <= w_cnt_next;
            r_frame_done <= w_wrap;
            r_an_n       <= w_show ? ~(4'b0001 << r_scan_q) : AN_OFF;
            r_seg_n      <= w_show ? w_seg_n : SEG_BLANK;
            r_dp_n       <= ~(w_show && r_active.dp[r_scan_q]);
        end
    end

    // a load coinciding with the wrap bypasses the shadow so it shows in the new frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else if (w_wrap) begin
            r_active  <= load ? w_in : (r_pending ? r_shadow : r_active);
            r_pending <= 1'b0;
            if (load) r_shadow <= w_in;
        end else if (load) begin
            r_shadow  <= w_in;
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_end ? '0 : r_blink_cnt + 1'b1;
            if (w_blink_end) r_blink_off <= ~r_blink_off;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign frame_done = r_frame_done;
endmodule
